// File: rtl/phase_step_write_scheduler.sv
// rtl/phase_step_write_scheduler.sv - operator sequencer with tear-free two-lane phase step writes
//
// Presents one voice operator ID per clock to the phase accumulation stage and
// splits each accepted 16-bit phase step write into a high-byte and a low-byte
// config write. The low-byte write is never issued while its target operator is
// being presented, so the stage never reads a half-updated step.
//
// Ports:
//   i_Clock                       system clock
//   i_Reset_n                     synchronous active-low reset
//   i_ConfigValid / o_ConfigReady write request handshake
//   i_ConfigAddr / i_ConfigData   target operator and 16-bit phase step
//   o_VoiceOperator               operator presented to the stage this cycle
//   o_SampleTick                  high while the last operator of the frame is presented
//   o_PhaseStepConfigWriteEnable  lane enables: [0] = bits 15:8, [1] = bits 7:0
//   o_PhaseStepConfigWriteAddr    config write address
//   o_PhaseStepConfigWriteData    config write byte
//   o_Busy                        a write is pending or in flight
module phase_step_write_scheduler #(
    parameter int NUM_VOICE_OPERATORS = 256,
    parameter int ID_WIDTH            = $clog2(NUM_VOICE_OPERATORS)
) (
    input  logic                i_Clock,
    input  logic                i_Reset_n,
    input  logic                i_ConfigValid,
    output logic                o_ConfigReady,
    input  logic [ID_WIDTH-1:0] i_ConfigAddr,
    input  logic [15:0]         i_ConfigData,
    output logic [ID_WIDTH-1:0] o_VoiceOperator,
    output logic                o_SampleTick,
    output logic [1:0]          o_PhaseStepConfigWriteEnable,
    output logic [ID_WIDTH-1:0] o_PhaseStepConfigWriteAddr,
    output logic [7:0]          o_PhaseStepConfigWriteData,
    output logic                o_Busy
);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_VOICE_OPERATORS - 1);
    localparam logic [ID_WIDTH:0]   NUM_OPS = (ID_WIDTH + 1)'(NUM_VOICE_OPERATORS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HI,
        ST_LO
    } state_t;

    state_t              state;
    state_t              next_state;

    logic [ID_WIDTH-1:0] req_addr;
    logic [15:0]         req_data;
    logic                accept;
    logic [ID_WIDTH-1:0] next_voice;
    logic [ID_WIDTH:0]   lo_sum;
    logic [ID_WIDTH-1:0] lo_voice;
    logic                lo_collides;

    logic                ready_d;
    logic                busy_d;
    logic [1:0]          we_d;
    logic [ID_WIDTH-1:0] addr_d;
    logic [7:0]          data_d;

    assign accept     = (state == ST_IDLE) && i_ConfigValid && o_ConfigReady;
    assign next_voice = (o_VoiceOperator == LAST_ID) ? '0 : o_VoiceOperator + ID_WIDTH'(1);

    // If HI were issued at the next edge, LO would be presented alongside the
    // operator two ahead of the current one. Wrap is done by a single
    // conditional subtract so non-power-of-two frame sizes work.
    assign lo_sum      = {1'b0, o_VoiceOperator} + (ID_WIDTH + 1)'(2);
    assign lo_voice    = (lo_sum >= NUM_OPS) ? ID_WIDTH'(lo_sum - NUM_OPS) : lo_sum[ID_WIDTH-1:0];
    assign lo_collides = (lo_voice == req_addr);

    // State and registered outputs
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state                        <= ST_IDLE;
            req_addr                     <= '0;
            req_data                     <= '0;
            o_VoiceOperator              <= '0;
            o_SampleTick                 <= 1'b0;
            o_ConfigReady                <= 1'b0;
            o_Busy                       <= 1'b0;
            o_PhaseStepConfigWriteEnable <= 2'b00;
            o_PhaseStepConfigWriteAddr   <= '0;
            o_PhaseStepConfigWriteData   <= '0;
        end else begin
            state                        <= next_state;
            o_VoiceOperator              <= next_voice;
            o_SampleTick                 <= (next_voice == LAST_ID);
            o_ConfigReady                <= ready_d;
            o_Busy                       <= busy_d;
            o_PhaseStepConfigWriteEnable <= we_d;
            o_PhaseStepConfigWriteAddr   <= addr_d;
            o_PhaseStepConfigWriteData   <= data_d;
            if (accept) begin
                req_addr <= i_ConfigAddr;
                req_data <= i_ConfigData;
            end
        end
    end

    // Next state
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = ST_WAIT;
            ST_WAIT: if (!lo_collides) next_state = ST_HI;
            ST_HI:   next_state = ST_LO;
            ST_LO:   next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it once registered
    always_comb begin
        ready_d = (next_state == ST_IDLE);
        busy_d  = (next_state != ST_IDLE);
        we_d    = 2'b00;
        addr_d  = o_PhaseStepConfigWriteAddr;
        data_d  = o_PhaseStepConfigWriteData;
        case (next_state)
            ST_HI: begin
                we_d   = 2'b01;
                addr_d = req_addr;
                data_d = req_data[15:8];
            end
            ST_LO: begin
                we_d   = 2'b10;
                addr_d = req_addr;
                data_d = req_data[7:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_phase_step_write_scheduler.sv
// tb/tb_phase_step_write_scheduler.sv - self-checking bench for phase_step_write_scheduler
module tb_phase_step_write_scheduler;
    localparam int N = 256;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         resetn;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_addr;
    logic [15:0]  cfg_data;
    logic [W-1:0] vop;
    logic         tick;
    logic [1:0]   we;
    logic [W-1:0] waddr;
    logic [7:0]   wdata;
    logic         busy;

    always #5 clk = ~clk;

    phase_step_write_scheduler #(.NUM_VOICE_OPERATORS(N)) dut (
        .i_Clock                      (clk),
        .i_Reset_n                    (resetn),
        .i_ConfigValid                (cfg_valid),
        .o_ConfigReady                (cfg_ready),
        .i_ConfigAddr                 (cfg_addr),
        .i_ConfigData                 (cfg_data),
        .o_VoiceOperator              (vop),
        .o_SampleTick                 (tick),
        .o_PhaseStepConfigWriteEnable (we),
        .o_PhaseStepConfigWriteAddr   (waddr),
        .o_PhaseStepConfigWriteData   (wdata),
        .o_Busy                       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Timeline model: cycles counted from reset release, writes as absolute cycle slots
    int           cyc = 0;
    logic         exp_ready = 1'b0;
    logic         last_acc = 1'b0;
    logic         m_active = 1'b0;
    int           m_hi, m_lo;
    logic [W-1:0] m_a;
    logic [15:0]  m_d;
    logic [W-1:0] m_last_addr = '0;
    logic [7:0]   m_last_data = '0;

    // Stage contents as seen by the stage, and the last fully-landed value per operator
    logic [15:0]  stage     [N];
    logic [15:0]  committed [N];
    logic [W-1:0] hi_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic       rst_edge;
        logic       acc;
        logic [1:0] ev_we;
        int         ev_vop;
        logic [15:0] rd;
        logic       legal;
        rst_edge = !resetn;
        acc      = resetn && cfg_valid && exp_ready;
        @(posedge clk);
        #1;
        last_acc = 1'b0;
        if (rst_edge) begin
            if (m_active) committed[m_a] = stage[m_a];
            m_active    = 1'b0;
            cyc         = 0;
            exp_ready   = 1'b0;
            m_last_addr = '0;
            m_last_data = '0;
            chk("rst_vop", vop, 0);
            chk("rst_tick", tick, 0);
            chk("rst_we", we, 0);
            chk("rst_addr", waddr, 0);
            chk("rst_data", wdata, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", cfg_ready, 0);
            return;
        end
        cyc++;
        if (m_active && cyc > m_lo) begin
            committed[m_a] = m_d;
            m_active = 1'b0;
        end
        if (acc) begin
            m_active = 1'b1;
            m_a      = cfg_addr;
            m_d      = cfg_data;
            last_acc = 1'b1;
            // LO would land on the operator two past the WAIT cycle's one; slip a cycle if that is A
            m_hi = (((cyc % N) + 2) % N != int'(m_a)) ? cyc + 1 : cyc + 2;
            m_lo = m_hi + 1;
        end
        ev_we = 2'b00;
        if (m_active && cyc == m_hi) begin
            ev_we = 2'b01; m_last_addr = m_a; m_last_data = m_d[15:8];
        end
        if (m_active && cyc == m_lo) begin
            ev_we = 2'b10; m_last_addr = m_a; m_last_data = m_d[7:0];
        end
        exp_ready = !m_active;
        ev_vop    = cyc % N;

        chk("vop", vop, ev_vop);
        chk("tick", tick, (ev_vop == N - 1) ? 1 : 0);
        chk("we", we, ev_we);
        chk("waddr", waddr, m_last_addr);
        chk("wdata", wdata, m_last_data);
        chk("busy", busy, m_active);
        chk("ready", cfg_ready, exp_ready);

        // Stage reads the presented operator before this cycle's write lands
        rd    = stage[ev_vop];
        legal = (rd === committed[ev_vop]) || (m_active && int'(m_a) == ev_vop && rd === m_d);
        chk("torn_read", legal, 1);

        if (we === 2'b01) hi_log.push_back(waddr);
        if (we[0] === 1'b1) stage[waddr][15:8] = wdata;
        if (we[1] === 1'b1) stage[waddr][7:0]  = wdata;
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while (!exp_ready && g < 20) begin
            step();
            g++;
        end
        chk(name, exp_ready, 1);
    endtask

    typedef struct {
        logic [W-1:0] addr;
        logic [15:0]  data;
        int           launch_vop;
        int           hi_lat;
        int           rdy_lat;
    } vec_t;

    vec_t vecs[6];

    typedef struct {
        logic [W-1:0] addr;
        logic [15:0]  data;
    } req_t;

    req_t hs[4];

    initial begin
        int g;
        int hi_t;
        int rdy_t;
        int bad;

        vecs[0] = '{8'd10,  16'hABCD, 100, 1, 3};
        vecs[1] = '{8'd5,   16'h1234, 2,   2, 4};
        vecs[2] = '{8'd1,   16'h9C3E, 254, 2, 4};
        vecs[3] = '{8'd2,   16'h7F01, 253, 1, 3};
        vecs[4] = '{8'd255, 16'hC0DE, 252, 2, 4};
        vecs[5] = '{8'd200, 16'h11FF, 197, 2, 4};

        hs[0] = '{8'd7,  16'hA1B2};
        hs[1] = '{8'd20, 16'h3344};
        hs[2] = '{8'd7,  16'hC3D4};
        hs[3] = '{8'd33, 16'h5566};

        for (int a = 0; a < N; a++) begin
            stage[a]     = 16'h0000;
            committed[a] = 16'h0000;
        end

        resetn    = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        repeat (3) step();
        resetn = 1'b1;
        step();
        chk("first_ready", cfg_ready, 1);

        // Directed vectors: unblocked, blocked, and both sides of the frame wrap
        for (int i = 0; i < 6; i++) begin
            g = 0;
            while (!(exp_ready && (cyc % N) == vecs[i].launch_vop) && g < 600) begin
                step();
                g++;
            end
            chk("vec_launch_reached", (g < 600) ? 1 : 0, 1);
            cfg_valid = 1'b1;
            cfg_addr  = vecs[i].addr;
            cfg_data  = vecs[i].data;
            step();
            cfg_valid = 1'b0;
            hi_t  = -1;
            rdy_t = -1;
            for (int t = 1; t <= 8 && rdy_t < 0; t++) begin
                step();
                if (hi_t < 0 && we === 2'b01) begin
                    hi_t = t;
                    chk("vec_hi_addr", waddr, vecs[i].addr);
                    chk("vec_hi_data", wdata, vecs[i].data[15:8]);
                end
                if (we === 2'b10) begin
                    chk("vec_lo_data", wdata, vecs[i].data[7:0]);
                    chk("vec_lo_not_target", (vop != vecs[i].addr) ? 1 : 0, 1);
                end
                if (cfg_ready === 1'b1) rdy_t = t;
            end
            chk("vec_hi_latency", hi_t, vecs[i].hi_lat);
            chk("vec_ready_latency", rdy_t, vecs[i].rdy_lat);
            chk("vec_stage_value", stage[vecs[i].addr], vecs[i].data);
        end

        // Held valid with a queue of requests: one acceptance per idle, in order
        wait_idle("hs_idle");
        hi_log.delete();
        for (int j = 0; j < 4; j++) begin
            cfg_valid = 1'b1;
            cfg_addr  = hs[j].addr;
            cfg_data  = hs[j].data;
            g = 0;
            do begin
                step();
                g++;
            end while (!last_acc && g < 12);
            chk("hs_accept", last_acc, 1);
        end
        cfg_valid = 1'b0;
        wait_idle("hs_drain");
        chk("hs_count", hi_log.size(), 4);
        for (int j = 0; j < 4 && j < hi_log.size(); j++) chk("hs_order", hi_log[j], hs[j].addr);
        chk("hs_last_wins", stage[7], 16'hC3D4);

        // Reset asserted during the HI cycle
        cfg_valid = 1'b1;
        cfg_addr  = 8'd40;
        cfg_data  = 16'h6677;
        step();
        cfg_valid = 1'b0;
        g = 0;
        while (we !== 2'b01 && g < 8) begin
            step();
            g++;
        end
        chk("rstmid_hi_seen", we, 2'b01);
        resetn = 1'b0;
        step();
        chk("rstmid_we", we, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_vop", vop, 0);
        step();
        resetn = 1'b1;
        step();
        chk("rstmid_ready_after", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_addr  = 8'd40;
        cfg_data  = 16'h6677;
        g = 0;
        do begin
            step();
            g++;
        end while (!last_acc && g < 12);
        cfg_valid = 1'b0;
        wait_idle("rewrite_drain");
        chk("rewrite_value", stage[40], 16'h6677);

        // Random traffic, biased toward addresses just ahead of the sequencer
        for (int c = 0; c < 3000; c++) begin
            if (!cfg_valid && $urandom_range(0, 2) == 0) begin
                cfg_valid = 1'b1;
                if ($urandom_range(0, 1) == 1)
                    cfg_addr = W'((cyc + int'($urandom_range(1, 5))) % N);
                else
                    cfg_addr = W'($urandom_range(0, N - 1));
                cfg_data = 16'($urandom);
            end
            step();
            if (last_acc) cfg_valid = 1'b0;
        end
        cfg_valid = 1'b0;
        wait_idle("rand_drain");
        step();

        bad = 0;
        for (int a = 0; a < N; a++) if (stage[a] !== committed[a]) bad++;
        chk("final_stage_mismatches", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_step_write_scheduler.md
Name: phase_step_write_scheduler

Overview:
- Drives the voice-operator sequence into the phase accumulation stage: one operator ID per clock, wrapping every frame, with a frame strobe.
- Accepts 16-bit phase-step writes from the register interface over a valid/ready handshake.
- Splits each write into the stage's two byte-lane config writes and schedules them so that no operator ever reads a half-updated (torn) phase step.

Parameters:
- NUM_VOICE_OPERATORS, 256, operators per frame (≥4, need not be a power of two)
- ID_WIDTH, $clog2(NUM_VOICE_OPERATORS), width of operator IDs

Ports:
- i_Clock  in  1  system clock
- i_Reset_n  in  1  reset
- i_ConfigValid  in  1  write request valid
- o_ConfigReady  out  1  scheduler can accept a request
- i_ConfigAddr  in  ID_WIDTH  target operator
- i_ConfigData  in  16  unsigned phase step
- o_VoiceOperator  out  ID_WIDTH  operator ID presented to the stage this cycle
- o_SampleTick  out  1  high while the last operator of the frame is presented
- o_PhaseStepConfigWriteEnable  out  2  byte lanes: [0] = bits 15:8, [1] = bits 7:0
- o_PhaseStepConfigWriteAddr  out  ID_WIDTH  config write address
- o_PhaseStepConfigWriteData  out  8  config write byte
- o_Busy  out  1  a write is pending or in flight

Behaviour:
- Clocking and reset: single clock i_Clock; reset is synchronous, active-low (i_Reset_n). All outputs are registered.
- Reset values: o_VoiceOperator=0, o_SampleTick=0, WriteEnable=2'b00, WriteAddr=0, WriteData=0, o_Busy=0, o_ConfigReady=0 while i_Reset_n=0. o_ConfigReady=1 on the first cycle after reset release.
- Sequencer: o_VoiceOperator increments by 1 every clock and wraps from NUM_VOICE_OPERATORS-1 to 0. It never stalls, including during config writes.
- o_SampleTick: high exactly in cycles where o_VoiceOperator==NUM_VOICE_OPERATORS-1, so one cycle per NUM_VOICE_OPERATORS clocks.
- Timing model: the stage samples o_VoiceOperator and applies the write-enable outputs at the same clock edge. A read at that edge returns the pre-write contents.
- Write FSM states:
  - IDLE: o_ConfigReady=1, o_Busy=0. On i_ConfigValid & o_ConfigReady, latch addr A and data D, go to WAIT. Requests with valid=0, or arriving while not ready, are ignored. The requester holds its request until accepted.
  - WAIT: o_ConfigReady=0, o_Busy=1. At an edge where (o_VoiceOperator+2) mod NUM_VOICE_OPERATORS != A, go to HI; otherwise stay in WAIT. Stalls at most 1 cycle per attempt.
  - HI: one cycle. WriteEnable=2'b01, WriteAddr=A, WriteData=D[15:8]. Go to LO.
  - LO: one cycle. WriteEnable=2'b10, WriteAddr=A, WriteData=D[7:0]. Go to IDLE.
- Tear guarantee: operator A is never presented in the LO cycle. Any read of A therefore returns either the full old value or the full new value.
- Write enables are 2'b00 in IDLE and WAIT. WriteAddr and WriteData hold their last values when the enables are 0.
- Latency:
  - Accept edge to HI: 1 cycle (WAIT held one cycle) when unblocked, 2 cycles when blocked.
  - Back in IDLE (o_ConfigReady=1) 3–4 cycles after accept.
  - Throughput: one write per 4–5 cycles.
- Back-to-back writes to the same address are serviced in order. A later write always wins.
- Reset asserted mid-write: FSM returns to IDLE and the enables drop on the next edge. A completed HI without its LO leaves a torn value in the stage; software must rewrite after reset. The stage's accumulators are not cleared by this block.

Test Plan:
- Reset: hold i_Reset_n=0 for 3 cycles -> all outputs 0. Release -> o_VoiceOperator counts 0,1,2…; o_ConfigReady=1; o_SampleTick high only at ID 255, period 256 cycles.
- Unblocked write: accept A=10, D=16'hABCD while o_VoiceOperator=100 -> HI cycle with WE=01, addr 10, data AB; next cycle WE=10, data CD; o_ConfigReady high again 3 cycles after accept.
- Blocked write: accept A=5 timed so that (o_VoiceOperator+2) mod 256==5 at the WAIT edge -> one extra WAIT cycle. Operator 5 is never presented during the LO cycle; a scoreboard model of the stage sees only 0x0000 or the full new value for operator 5.
- Wrap boundary: A=1 with the ID sequence crossing 255->0 -> tear rule evaluated modulo 256; ensures no torn read of operator 1.
- Handshake: hold i_ConfigValid with 4 queued writes (including two to A=7) -> exactly one acceptance per IDLE, in order; final stage value for A=7 is the second write's data.
- Reset mid-write: assert i_Reset_n=0 during the HI cycle -> the next cycle has WE=00, FSM in IDLE, o_Busy=0, o_VoiceOperator=0.
